dft: RTL and testbench

DFT -- requirements
Module: dft

---
 rtl/dft_pkg.sv | 58 +++++
 rtl/dft_cmac.sv | 74 +++++++
 rtl/dft.sv | 190 +++++++++++++++++++
 tb/tb_dft.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// ---------------------------------------------------------------------------
// dft_pkg -- shared constants and types for the 8-point forward DFT.
//   DFT_N       : points per frame
//   TW_W        : twiddle width (signed)
//   TW_FRAC     : twiddle fractional bits (Q2.14)
//   ACC_GUARD   : accumulator width above the sample width
//   state_e     : LOAD / MAC / EMIT control states
//   tw_cos/sin  : 8-entry twiddle tables indexed by m = (k*n) mod 8
// ---------------------------------------------------------------------------
package dft_pkg;

  localparam int DFT_N     = 8;
  localparam int TW_W      = 16;
  localparam int TW_FRAC   = 14;
  localparam int ACC_GUARD = 19;

  localparam logic signed [TW_W-1:0] TW_ONE  = 16'sd16384;  // 1.0 in Q2.14
  localparam logic signed [TW_W-1:0] TW_HALF = 16'sd11585;  // sqrt(2)/2 in Q2.14

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_MAC  = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  // cos(2*pi*m/8)
  function automatic logic signed [TW_W-1:0] tw_cos(input logic [2:0] m);
    logic signed [TW_W-1:0] v;
    case (m)
      3'd0:    v = TW_ONE;
      3'd1:    v = TW_HALF;
      3'd2:    v = '0;
      3'd3:    v = -TW_HALF;
      3'd4:    v = -TW_ONE;
      3'd5:    v = -TW_HALF;
      3'd6:    v = '0;
      default: v = TW_HALF;
    endcase
    return v;
  endfunction

  // sin(2*pi*m/8)
  function automatic logic signed [TW_W-1:0] tw_sin(input logic [2:0] m);
    logic signed [TW_W-1:0] v;
    case (m)
      3'd0:    v = '0;
      3'd1:    v = TW_HALF;
      3'd2:    v = TW_ONE;
      3'd3:    v = TW_HALF;
      3'd4:    v = '0;
      3'd5:    v = -TW_HALF;
      3'd6:    v = -TW_ONE;
      default: v = -TW_HALF;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dft_cmac.sv
// ---------------------------------------------------------------------------
// dft_cmac -- registered complex multiply-accumulate with twiddle lookup.
//   clk, rst_n      : clock, async active-low reset (clears accumulator)
//   en              : perform one MAC step this cycle
//   load            : with en, load the product instead of accumulating
//   x_re, x_im      : complex sample (signed BITS)
//   m               : twiddle index (k*n mod 8)
//   acc_re, acc_im  : accumulator (signed BITS+ACC_GUARD)
// Product convention (forward transform, W = cos - j sin):
//   re = xr*c + xi*s,  im = xi*c - xr*s
// ---------------------------------------------------------------------------
module dft_cmac
  import dft_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load,
  input  logic signed [BITS-1:0]        x_re,
  input  logic signed [BITS-1:0]        x_im,
  input  logic [2:0]                    m,
  output logic signed [BITS+ACC_GUARD-1:0] acc_re,
  output logic signed [BITS+ACC_GUARD-1:0] acc_im
);

  localparam int PW = BITS + TW_W;
  localparam int AW = BITS + ACC_GUARD;

  logic signed [TW_W-1:0] c;
  logic signed [TW_W-1:0] s;
  logic signed [PW-1:0]   p_rc;
  logic signed [PW-1:0]   p_is;
  logic signed [PW-1:0]   p_ic;
  logic signed [PW-1:0]   p_rs;
  logic signed [AW-1:0]   t_re;
  logic signed [AW-1:0]   t_im;
  logic signed [AW-1:0]   acc_re_d, acc_re_q;
  logic signed [AW-1:0]   acc_im_d, acc_im_q;

  always_comb begin
    c    = tw_cos(m);
    s    = tw_sin(m);
    p_rc = x_re * c;
    p_is = x_im * s;
    p_ic = x_im * c;
    p_rs = x_re * s;
    // Sign-extend the products explicitly before combining them.
    t_re = {{(AW-PW){p_rc[PW-1]}}, p_rc} + {{(AW-PW){p_is[PW-1]}}, p_is};
    t_im = {{(AW-PW){p_ic[PW-1]}}, p_ic} - {{(AW-PW){p_rs[PW-1]}}, p_rs};

    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    if (en) begin
      acc_re_d = load ? t_re : acc_re_q + t_re;
      acc_im_d = load ? t_im : acc_im_q + t_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
    end
  end

  assign acc_re = acc_re_q;
  assign acc_im = acc_im_q;

endmodule

// File: rtl/dft.sv
// ---------------------------------------------------------------------------
// dft -- 8-point forward DFT, one complex MAC per cycle.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : input handshake; a sample is taken on every rising
//                         edge where both are 1. in_ready is 1 only in LOAD,
//                         so in_valid outside LOAD is ignored.
//   in, j_in            : real / imaginary time-domain sample (signed BITS)
//   out_valid           : one-cycle pulse per bin, no backpressure
//   out, j_out          : saturated bin value, held between pulses
//   out_index           : bin index k of the current pulse
//   frame_done          : pulses with the k=7 bin
//   dbg_state           : current control state (state_e encoding)
// Per bin: 8 MAC cycles then 1 EMIT cycle, so bin k appears 9*(k+1) edges
// after the edge that accepted the last sample.
// ---------------------------------------------------------------------------
module dft
  import dft_pkg::*;
#(
  parameter int BITS = 16,
  parameter int N    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [BITS-1:0] in,
  input  logic signed [BITS-1:0] j_in,
  output logic                   out_valid,
  output logic signed [BITS-1:0] out,
  output logic signed [BITS-1:0] j_out,
  output logic [2:0]             out_index,
  output logic                   frame_done,
  output logic [1:0]             dbg_state
);

  localparam int         AW   = BITS + ACC_GUARD;
  localparam logic [2:0] LAST = 3'(N - 1);

  state_e                 state_d, state_q;
  logic [2:0]             n_d, n_q;
  logic [2:0]             k_d, k_q;
  logic                   in_ready_d, in_ready_q;
  logic                   out_valid_d, out_valid_q;
  logic                   frame_done_d, frame_done_q;
  logic signed [BITS-1:0] out_d, out_q;
  logic signed [BITS-1:0] j_out_d, j_out_q;
  logic [2:0]             out_index_d, out_index_q;

  logic                   accept;
  logic signed [BITS-1:0] buf_re_q [DFT_N];
  logic signed [BITS-1:0] buf_im_q [DFT_N];

  logic                   mac_en;
  logic                   mac_load;
  logic [2:0]             mac_m;
  logic signed [AW-1:0]   acc_re;
  logic signed [AW-1:0]   acc_im;

  // Floor-shift by the twiddle fraction, then clamp to the output range.
  // The value fits iff every bit from the sign down to bit BITS-1 agrees.
  function automatic logic signed [BITS-1:0] sat_out(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] sh;
    logic signed [BITS-1:0] r;
    sh = acc >>> TW_FRAC;
    if ((&sh[AW-1:BITS-1]) || !(|sh[AW-1:BITS-1])) begin
      r = sh[BITS-1:0];
    end else if (sh[AW-1]) begin
      r = {1'b1, {(BITS-1){1'b0}}};
    end else begin
      r = {1'b0, {(BITS-1){1'b1}}};
    end
    return r;
  endfunction

  assign accept   = in_valid && in_ready_q;
  assign mac_en   = (state_q == S_MAC);
  assign mac_load = (n_q == 3'd0);
  assign mac_m    = k_q * n_q;  // 3-bit result wraps modulo 8

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    k_d          = k_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    out_d        = out_q;
    j_out_d      = j_out_q;
    out_index_d  = out_index_q;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (n_q == LAST) begin
            state_d    = S_MAC;
            n_d        = 3'd0;
            k_d        = 3'd0;
            in_ready_d = 1'b0;
          end else begin
            n_d = n_q + 3'd1;
          end
        end
      end
      S_MAC: begin
        if (n_q == LAST) begin
          state_d = S_EMIT;
          n_d     = 3'd0;
        end else begin
          n_d = n_q + 3'd1;
        end
      end
      S_EMIT: begin
        out_valid_d = 1'b1;
        out_d       = sat_out(acc_re);
        j_out_d     = sat_out(acc_im);
        out_index_d = k_q;
        if (k_q == LAST) begin
          frame_done_d = 1'b1;
          state_d      = S_LOAD;
          k_d          = 3'd0;
          n_d          = 3'd0;
          in_ready_d   = 1'b1;
        end else begin
          k_d     = k_q + 3'd1;
          n_d     = 3'd0;
          state_d = S_MAC;
        end
      end
      default: begin
        state_d    = S_LOAD;
        n_d        = 3'd0;
        k_d        = 3'd0;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      n_q          <= 3'd0;
      k_q          <= 3'd0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_q        <= '0;
      j_out_q      <= '0;
      out_index_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      k_q          <= k_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      out_q        <= out_d;
      j_out_q      <= j_out_d;
      out_index_q  <= out_index_d;
    end
  end

  // Sample buffer: no reset needed, every entry is rewritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_re_q[n_q] <= in;
      buf_im_q[n_q] <= j_in;
    end
  end

  dft_cmac #(.BITS(BITS)) u_cmac (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mac_en),
    .load   (mac_load),
    .x_re   (buf_re_q[n_q]),
    .x_im   (buf_im_q[n_q]),
    .m      (mac_m),
    .acc_re (acc_re),
    .acc_im (acc_im)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign j_out      = j_out_q;
  assign out_index  = out_index_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dft.sv
// ---------------------------------------------------------------------------
// tb_dft -- directed + random frames for the 8-point forward DFT.
// Expected bins come from a direct evaluation of the DFT sum with twiddles
// rounded from real cos/sin, floor scaling and clamping.
// ---------------------------------------------------------------------------
module tb_dft;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic signed [15:0] xj_in;
  logic               out_valid;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;
  logic [2:0]         out_index;
  logic               frame_done;
  logic [1:0]         dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_last = 0;

  int xr [8];
  int xi [8];
  int er [8];
  int ei [8];

  dft #(.BITS(16), .N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in         (x_in),
    .j_in       (xj_in),
    .out_valid  (out_valid),
    .out        (out_re),
    .j_out      (out_im),
    .out_index  (out_index),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // clock / reset-independent cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int twid(input int m, input bit is_sin);
    real a;
    real v;
    a = 2.0 * 3.14159265358979 * m / 8.0;
    v = is_sin ? 16384.0 * $sin(a) : 16384.0 * $cos(a);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic model_frame();
    for (int k = 0; k < 8; k++) begin
      longint ar = 0;
      longint ai = 0;
      for (int n = 0; n < 8; n++) begin
        int c = twid((k * n) % 8, 1'b0);
        int s = twid((k * n) % 8, 1'b1);
        ar += longint'(xr[n]) * c + longint'(xi[n]) * s;
        ai += longint'(xi[n]) * c - longint'(xr[n]) * s;
      end
      er[k] = clamp16(ar >>> 14);
      ei[k] = clamp16(ai >>> 14);
    end
  endtask

  // ---------------- driver tasks (start and end at a negedge) ----------------
  task automatic send_frame(input int gap_max, input bit keep_valid);
    for (int i = 0; i < 8; i++) begin
      int b = 0;
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      x_in     = 16'(xr[i]);
      xj_in    = 16'(xi[i]);
      while (!in_ready && b < 200) begin
        @(negedge clk);
        b++;
      end
      if (b >= 200) check("accept_timeout", b, 0);
      t_last = cyc + 1;
      @(negedge clk);
    end
    if (!keep_valid) in_valid = 1'b0;
    check("in_ready_drop", in_ready, 0);
  endtask

  task automatic collect_frame(input bit keep_valid);
    logic signed [15:0] pr;
    for (int k = 0; k < 8; k++) begin
      int b = 0;
      while (!out_valid && b < 40) begin
        if (keep_valid) begin
          x_in  = 16'($urandom);
          xj_in = 16'($urandom);
        end
        @(negedge clk);
        b++;
      end
      check("bin_seen",   out_valid, 1);
      check("bin_re",     out_re, er[k]);
      check("bin_im",     out_im, ei[k]);
      check("bin_index",  out_index, k);
      check("frame_done", frame_done, (k == 7));
      check("bin_time",   cyc, t_last + 9 * (k + 1));
      check("ready_in_compute", in_ready, (k == 7));
      pr = out_re;
      if (k == 7) in_valid = 1'b0;
      @(negedge clk);
      check("pulse_len", out_valid, 0);
      check("hold_re",   out_re, pr);
    end
  endtask

  task automatic run_frame(input int gap_max);
    model_frame();
    send_frame(gap_max, 1'b0);
    collect_frame(1'b0);
  endtask

  task automatic load_impulse();
    for (int i = 0; i < 8; i++) begin
      xr[i] = 0;
      xi[i] = 0;
    end
    xr[0] = 100;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hits;
    int b;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    x_in     = '0;
    xj_in    = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",   in_ready, 1);
    check("rst_out_valid",  out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_out",        out_re, 0);
    check("rst_j_out",      out_im, 0);
    check("rst_out_index",  out_index, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // impulse
    load_impulse();
    run_frame(0);

    // DC
    for (int i = 0; i < 8; i++) begin
      xr[i] = 100;
      xi[i] = 0;
    end
    run_frame(2);

    // shifted impulse
    for (int i = 0; i < 8; i++) begin
      xr[i] = 0;
      xi[i] = 0;
    end
    xr[1] = 1000;
    run_frame(1);

    // saturation
    for (int i = 0; i < 8; i++) begin
      xr[i] = 32767;
      xi[i] = -32768;
    end
    run_frame(0);

    // random frames
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        xr[i] = int'($urandom_range(0, 65535)) - 32768;
        xi[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      run_frame(3);
    end

    // continuous in_valid, then a second frame straight after
    for (int i = 0; i < 8; i++) begin
      xr[i] = int'($urandom_range(0, 4000)) - 2000;
      xi[i] = int'($urandom_range(0, 4000)) - 2000;
    end
    model_frame();
    send_frame(0, 1'b1);
    collect_frame(1'b1);
    for (int i = 0; i < 8; i++) begin
      xr[i] = int'($urandom_range(0, 65535)) - 32768;
      xi[i] = int'($urandom_range(0, 65535)) - 32768;
    end
    run_frame(0);

    // reset while computing bin 3
    load_impulse();
    model_frame();
    send_frame(0, 1'b0);
    b = 0;
    while (!(out_valid && out_index == 3'd2) && b < 100) begin
      @(negedge clk);
      b++;
    end
    check("bin2_before_reset", out_index, 2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out",       out_re, 0);
    check("midrst_j_out",     out_im, 0);
    check("midrst_out_index", out_index, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check("no_out_after_reset", hits, 0);
    check("ready_after_reset",  in_ready, 1);
    run_frame(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
